// File: rtl/iir_eq_slicer.sv
// iir_eq_slicer: 2nd-order IIR receive equaliser with threshold slicer (option macro: EQ_DFE_EN adds a 1-tap DFE slicer correction)
// Latency: one cycle from an accepted in_valid sample to out_valid; one sample per cycle
// Backpressure: none; every in_valid cycle is consumed, there is no ready signal
module iir_eq_slicer #(
   parameter int DW = 16,
   parameter int CW = 16,
   parameter int CF = 12,
   parameter int OW = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   input  logic                 coef_we,
   input  logic [2:0]           coef_addr,
   input  logic signed [CW-1:0] coef_wdata,
   input  logic                 bypass,
   output logic                 out_valid,
   output logic signed [OW-1:0] out_data,
   output logic                 out_bit,
   output logic                 sat_flag
);

   // Accumulator wide enough for four full-precision products without wrap
   localparam int AW  = OW + CW + 2;
   localparam int OW1 = OW + 1;

   localparam logic signed [CW-1:0] A1_RST  = CW'(5833);
   localparam logic signed [CW-1:0] A2_RST  = CW'(-2048);
   localparam logic signed [CW-1:0] B1_RST  = CW'(29753);
   localparam logic signed [CW-1:0] B2_RST  = CW'(-29442);
   localparam logic signed [CW-1:0] THR_RST = CW'(16196);

   localparam logic signed [OW-1:0] Y_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic signed [OW-1:0] Y_MIN = {1'b1, {(OW-1){1'b0}}};

   logic signed [CW-1:0] a1, a2, b1, b2, thr;
   logic signed [DW-1:0] u1, u2;
   logic signed [OW-1:0] y1, y2;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] y_full;
   logic [AW-OW:0]       y_top;
   logic                 y_clamped;
   logic signed [OW-1:0] y_sat;
   logic                 slice_bit;
   logic signed [OW-1:0] byp_data;
   logic                 byp_bit;

`ifdef EQ_DFE_EN
   logic signed [CW-1:0] dfe_tap;
   logic                 dfe_prev;
   logic signed [OW1-1:0] y_adj;
`endif

   // Filter arithmetic, saturation and slicer decision for the current history
   always_comb begin
      acc = AW'(a1) * AW'(y1) + AW'(a2) * AW'(y2)
          + AW'(b1) * AW'(u1) + AW'(b2) * AW'(u2);
      // Arithmetic shift floors toward minus infinity, matching the fixed-point rounding intent
      y_full    = acc >>> CF;
      // Value fits in OW bits only when every bit above the OW-1 sign bit is a sign copy
      y_top     = y_full[AW-1:OW-1];
      y_clamped = !((&y_top) || !(|y_top));
      y_sat     = y_full[OW-1:0];
      if (y_clamped) begin
         y_sat = y_full[AW-1] ? Y_MIN : Y_MAX;
      end
`ifdef EQ_DFE_EN
      // Remove the post-cursor ISI contributed by the previous decision
      y_adj     = OW1'(y_sat) - (dfe_prev ? OW1'(dfe_tap) : -OW1'(dfe_tap));
      slice_bit = (y_adj >= OW1'(thr));
`else
      slice_bit = (y_sat >= OW'(thr));
`endif
      byp_data  = OW'(in_data);
      byp_bit   = (byp_data >= OW'(thr));
   end

   // Coefficient and threshold registers; a write lands at the edge it is sampled on
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a1  <= A1_RST;
         a2  <= A2_RST;
         b1  <= B1_RST;
         b2  <= B2_RST;
         thr <= THR_RST;
`ifdef EQ_DFE_EN
         dfe_tap <= '0;
`endif
      end else if (coef_we) begin
         case (coef_addr)
            3'd0: a1  <= coef_wdata;
            3'd1: a2  <= coef_wdata;
            3'd2: b1  <= coef_wdata;
            3'd3: b2  <= coef_wdata;
            3'd4: thr <= coef_wdata;
`ifdef EQ_DFE_EN
            3'd5: dfe_tap <= coef_wdata;
`endif
            default: ;
         endcase
      end
   end

   // Sample history and output registers; bypass flushes history so the filter restarts clean
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         u1        <= '0;
         u2        <= '0;
         y1        <= '0;
         y2        <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_bit   <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         sat_flag  <= 1'b0;
         if (in_valid) begin
            if (bypass) begin
               out_data <= byp_data;
               out_bit  <= byp_bit;
               u1       <= '0;
               u2       <= '0;
               y1       <= '0;
               y2       <= '0;
            end else begin
               out_data <= y_sat;
               out_bit  <= slice_bit;
               sat_flag <= y_clamped;
               y2       <= y1;
               y1       <= y_sat;
               u2       <= u1;
               u1       <= in_data;
            end
         end
      end
   end

`ifdef EQ_DFE_EN
   // Previous filtered decision feeding the DFE correction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dfe_prev <= 1'b0;
      end else if (in_valid) begin
         dfe_prev <= bypass ? 1'b0 : slice_bit;
      end
   end
`endif

endmodule
